// File: rtl/alu_decoder.sv
// RV32I ALU control decoder: combinational alu_control_o from alu_op/funct3/op[5]/funct7[5],
// plus a registered copy and a registered flag for the unused alu_op class.
module alu_decoder (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [2:0] funct3_i,
   input  logic [1:0] alu_op_i,
   input  logic [6:0] op,
   input  logic [6:0] funct7_i,
   output logic [3:0] alu_control_o,
   output logic [3:0] alu_control_q_o,
   output logic       illegal_q_o
);

   localparam int unsigned CtrlW = 4;

   localparam logic [CtrlW-1:0] AluSrl  = CtrlW'(4'b0000);
   localparam logic [CtrlW-1:0] AluSra  = CtrlW'(4'b0001);
   localparam logic [CtrlW-1:0] AluAnd  = CtrlW'(4'b0010);
   localparam logic [CtrlW-1:0] AluOr   = CtrlW'(4'b0011);
   localparam logic [CtrlW-1:0] AluXor  = CtrlW'(4'b0100);
   localparam logic [CtrlW-1:0] AluSlt  = CtrlW'(4'b0101);
   localparam logic [CtrlW-1:0] AluSltu = CtrlW'(4'b0110);
   localparam logic [CtrlW-1:0] AluSll  = CtrlW'(4'b0111);
   localparam logic [CtrlW-1:0] AluAdd  = CtrlW'(4'b1000);
   localparam logic [CtrlW-1:0] AluSub  = CtrlW'(4'b1001);

   logic [CtrlW-1:0] alu_control_d;
   logic [CtrlW-1:0] alu_control_q;
   logic             illegal_d;
   logic             illegal_q;
   logic             unused_bits;

   // Only op[5] and funct7[5] take part in the decode.
   assign unused_bits = ^{op[6], op[4:0], funct7_i[6], funct7_i[4:0]};

   // Decode: the fixed classes never look at funct3/op/funct7, so X there cannot leak out.
   always_comb begin
      alu_control_d = AluSrl;
      illegal_d     = 1'b0;
      case (alu_op_i)
         2'b00: alu_control_d = AluAdd;
         2'b01: alu_control_d = AluSub;
         2'b10: begin
            case (funct3_i)
               3'b000:  alu_control_d = (op[5] && funct7_i[5]) ? AluSub : AluAdd;
               3'b001:  alu_control_d = AluSll;
               3'b010:  alu_control_d = AluSlt;
               3'b011:  alu_control_d = AluSltu;
               3'b100:  alu_control_d = AluXor;
               3'b101:  alu_control_d = funct7_i[5] ? AluSra : AluSrl;
               3'b110:  alu_control_d = AluOr;
               3'b111:  alu_control_d = AluAnd;
               default: alu_control_d = AluSrl;
            endcase
         end
         2'b11: begin
            alu_control_d = AluSrl;
            illegal_d     = 1'b1;
         end
         default: alu_control_d = AluSrl;
      endcase
   end

   assign alu_control_o = alu_control_d;

   // Pipeline copy with synchronous reset taking priority.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         alu_control_q <= AluSrl;
         illegal_q     <= 1'b0;
      end else begin
         alu_control_q <= alu_control_d;
         illegal_q     <= illegal_d;
      end
   end

   assign alu_control_q_o = alu_control_q;
   assign illegal_q_o     = illegal_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed corner cases, then random stimulus
// against a table-driven reference model of the ALU control rules.
module tb_alu_decoder;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [2:0] funct3_i;
   logic [1:0] alu_op_i;
   logic [6:0] op;
   logic [6:0] funct7_i;
   logic [3:0] alu_control_o;
   logic [3:0] alu_control_q_o;
   logic       illegal_q_o;

   int checks = 0;
   int errors = 0;

   // Base R/I-class code per funct3; SUB and SRA are refinements applied on top.
   logic [3:0] base_tbl [8] = '{4'd8, 4'd7, 4'd5, 4'd6, 4'd4, 4'd0, 4'd3, 4'd2};

   alu_decoder dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .funct3_i        (funct3_i),
      .alu_op_i        (alu_op_i),
      .op              (op),
      .funct7_i        (funct7_i),
      .alu_control_o   (alu_control_o),
      .alu_control_q_o (alu_control_q_o),
      .illegal_q_o     (illegal_q_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [3:0] ref_alu(input logic [1:0] aop, input logic [2:0] f3,
                                          input logic op5, input logic f75);
      logic [3:0] r;
      if (aop == 2'd0) return 4'd8;
      if (aop == 2'd1) return 4'd9;
      if (aop == 2'd3) return 4'd0;
      r = base_tbl[f3];
      if (f3 == 3'd0 && op5 && f75) r = 4'd9;
      if (f3 == 3'd5 && f75)        r = 4'd1;
      return r;
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] o,
                        input logic [6:0] f7);
      alu_op_i = aop;
      funct3_i = f3;
      op       = o;
      funct7_i = f7;
      #1;
   endtask

   initial begin
      logic [3:0] exp_c;
      logic [2:0] f3v;
      logic [2:0] f3_list [6];
      logic [3:0] exp_list [6];
      logic [3:0] sweep0 [4];
      logic [3:0] sweep5 [4];
      logic [6:0] o_r;
      logic [6:0] f7_r;

      f3_list  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
      exp_list = '{4'b0111, 4'b0101, 4'b0110, 4'b0100, 4'b0011, 4'b0010};
      sweep0   = '{4'b1000, 4'b1000, 4'b1000, 4'b1001};
      sweep5   = '{4'b0000, 4'b0001, 4'b0000, 4'b0001};

      reset_i = 1'b1;
      drive(2'b00, 3'bxxx, 7'bxxxxxxx, 7'bxxxxxxx);

      // Reset held for two edges.
      @(posedge clk_i); #1;
      check("rst_q_edge1", alu_control_q_o, 4'b0000);
      check("rst_ill_edge1", {3'b0, illegal_q_o}, 4'b0000);
      @(posedge clk_i); #1;
      check("rst_q_edge2", alu_control_q_o, 4'b0000);
      check("rst_ill_edge2", {3'b0, illegal_q_o}, 4'b0000);

      // Fixed classes ignore X in the other fields.
      @(negedge clk_i);
      drive(2'b00, 3'bxxx, 7'bxxxxxxx, 7'bxxxxxxx);
      check("ldst_add_x", alu_control_o, 4'b1000);
      drive(2'b01, 3'bxxx, 7'bxxxxxxx, 7'bxxxxxxx);
      check("branch_sub_x", alu_control_o, 4'b1001);

      // ADD/SUB and SRL/SRA sweeps over {op[5], funct7[5]}.
      for (int i = 0; i < 4; i++) begin
         drive(2'b10, 3'b000, {1'b0, i[1], 5'b0}, {1'b0, i[0], 5'b0});
         check($sformatf("f3_000_sweep%0d", i), alu_control_o, sweep0[i]);
         drive(2'b10, 3'b101, {1'b0, i[1], 5'b0}, {1'b0, i[0], 5'b0});
         check($sformatf("f3_101_sweep%0d", i), alu_control_o, sweep5[i]);
      end

      // Remaining funct3 codes, with unused op/funct7 bits held low then toggled.
      for (int i = 0; i < 6; i++) begin
         drive(2'b10, f3_list[i], 7'b0000000, 7'b0000000);
         check($sformatf("f3_%0d_plain", f3_list[i]), alu_control_o, exp_list[i]);
         drive(2'b10, f3_list[i], 7'b1011111, 7'b1011111);
         check($sformatf("f3_%0d_unused_bits", f3_list[i]), alu_control_o, exp_list[i]);
      end

      // Unused bits never flip ADD to SUB or SRL to SRA.
      drive(2'b10, 3'b000, 7'b1011111, 7'b1011111);
      check("add_unused_bits", alu_control_o, 4'b1000);
      drive(2'b10, 3'b101, 7'b1011111, 7'b1011111);
      check("srl_unused_bits", alu_control_o, 4'b0000);

      // alu_op 11 with reset released.
      reset_i = 1'b0;
      drive(2'b11, 3'b010, 7'b0110011, 7'b0100000);
      check("illegal_comb", alu_control_o, 4'b0000);
      @(posedge clk_i); #1;
      check("illegal_q_flag", {3'b0, illegal_q_o}, 4'b0001);
      check("illegal_q_ctrl", alu_control_q_o, 4'b0000);

      // SUB captured one edge after being applied.
      @(negedge clk_i);
      drive(2'b10, 3'b000, 7'b0110011, 7'b0100000);
      check("sub_comb", alu_control_o, 4'b1001);
      @(posedge clk_i); #1;
      check("sub_q", alu_control_q_o, 4'b1001);
      check("sub_q_ill", {3'b0, illegal_q_o}, 4'b0000);

      // Mid-stream reset clears registers, combinational path untouched.
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      check("rst_comb_hold", alu_control_o, 4'b1001);
      @(posedge clk_i); #1;
      check("rst_mid_q", alu_control_q_o, 4'b0000);
      check("rst_mid_comb", alu_control_o, 4'b1001);

      // First edge after release captures the current decode.
      @(negedge clk_i);
      reset_i = 1'b0;
      drive(2'b10, 3'b011, 7'b0010011, 7'b0000000);
      @(posedge clk_i); #1;
      check("post_rst_q", alu_control_q_o, 4'b0110);

      // Random stimulus against the reference model.
      for (int n = 0; n < 300; n++) begin
         @(negedge clk_i);
         reset_i = ($urandom_range(0, 9) == 0);
         f3v  = 3'($urandom_range(0, 7));
         o_r  = 7'($urandom);
         f7_r = 7'($urandom);
         drive(2'($urandom_range(0, 3)), f3v, o_r, f7_r);
         exp_c = ref_alu(alu_op_i, funct3_i, op[5], funct7_i[5]);
         check("rand_comb", alu_control_o, exp_c);
         @(posedge clk_i); #1;
         check("rand_q", alu_control_q_o, reset_i ? 4'b0000 : exp_c);
         check("rand_ill", {3'b0, illegal_q_o},
               {3'b0, (!reset_i && alu_op_i == 2'b11)});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
